// File: rtl/adc_sample_stream_if.sv
// Bundle of the Avalon-MM read-master signals toward the ADC slave and the
// valid/ready sample stream toward the consumer.
interface adc_sample_stream_if;
    logic [9:0]  m_address;
    logic        m_read;
    logic        m_burstcount;
    logic [1:0]  m_byteenable;
    logic [15:0] m_readdata;
    logic        m_waitrequest;
    logic        m_readdatavalid;

    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output m_address,
        output m_read,
        output m_burstcount,
        output m_byteenable,
        input  m_readdata,
        input  m_waitrequest,
        input  m_readdatavalid,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  m_address,
        input  m_read,
        input  m_burstcount,
        input  m_byteenable,
        output m_readdata,
        output m_waitrequest,
        output m_readdatavalid,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/adc_sample_stream.sv
// Timer-paced single-word reader for the MAX10 ADC slave: averages 2^AVG_LOG2
// raw results per output sample and streams them out through a 16-deep FIFO.
module adc_sample_stream #(
    parameter int unsigned DIV      = 1000,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned TIMEOUT  = 4096,
    parameter logic [9:0]  ADC_ADDR = 10'h000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                clr_status,
    adc_sample_stream_if.master bus,
    output logic [2:0]          status,
    output logic [4:0]          fill
);

    localparam int unsigned ACC_W   = 12 + AVG_LOG2;
    localparam int unsigned CNT_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned N_AVG   = 1 << AVG_LOG2;
    localparam int unsigned DEPTH   = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] timer;
    logic        tick;
    logic [15:0] wait_cnt;
    logic        read_req;
    logic        capture;
    logic        timeout_evt;
    logic        overrun_evt;
    logic        overflow_evt;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt;
    logic             push_q;
    logic [11:0]      push_word;

    logic [11:0] mem [DEPTH];
    logic [3:0]  wr_ptr, rd_ptr;
    logic [4:0]  count;
    logic        full, pop, wr_en;
    logic [2:0]  status_q;

    logic unused_readdata_hi;
    assign unused_readdata_hi = ^bus.m_readdata[15:12];

    assign bus.m_address    = ADC_ADDR;
    assign bus.m_burstcount = 1'b1;
    assign bus.m_byteenable = 2'b11;

    // Sample timer: the tick is the cycle in which the counter wraps back to 0.
    assign tick = enable && (timer == 16'(DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (!enable || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= (state_q == ST_WAIT) ? wait_cnt + 16'd1 : 16'd0;
        end
    end

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        read_req    = 1'b0;
        capture     = 1'b0;
        timeout_evt = 1'b0;
        overrun_evt = tick && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (tick) state_d = ST_REQ;
            end
            ST_REQ: begin
                read_req = 1'b1;
                if (!bus.m_waitrequest) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.m_readdatavalid) begin
                    capture = 1'b1;
                    state_d = ST_DRAIN;
                end else if (wait_cnt == 16'(TIMEOUT - 1)) begin
                    timeout_evt = 1'b1;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A readdatavalid held high past the capture is swallowed here.
                if (!bus.m_readdatavalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.m_read = read_req;

    assign acc_sum = acc + ACC_W'(bus.m_readdata[11:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            push_q    <= 1'b0;
            push_word <= '0;
        end else begin
            push_q <= 1'b0;
            if (capture) begin
                if (cnt == CNT_W'(N_AVG - 1)) begin
                    push_q    <= 1'b1;
                    push_word <= acc_sum[ACC_W-1:AVG_LOG2];
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign full          = (count == 5'(DEPTH));
    assign bus.out_valid = (count != 5'd0);
    assign pop           = bus.out_valid && bus.out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en         = push_q && (!full || pop);
    assign overflow_evt  = push_q && full && !pop;

    // NOTE: the storage array has no reset; validity is tracked by count, and
    // out_data is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 4'd1;
            if (pop)   rd_ptr <= rd_ptr + 4'd1;
            case ({wr_en, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    assign bus.out_data = bus.out_valid ? mem[rd_ptr] : 12'd0;
    assign fill         = count;

    // Sticky flags; a set event in the same cycle as clr_status wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q <= '0;
        end else begin
            status_q <= (clr_status ? 3'b000 : status_q)
                      | {timeout_evt, overflow_evt, overrun_evt};
        end
    end

    assign status = status_q;

endmodule
